// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared opcodes, instruction field positions and FSM state type for mau_host_ctrl
package mau_pkg;

  // Instruction field bit positions
  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 6;
  localparam int OPC_MSB = 3;
  localparam int OPC_LSB = 2;

  // Opcodes carried in host_instruction[OPC_MSB:OPC_LSB]
  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_LOAD  = 2'b01;
  localparam logic [1:0] OPC_STORE = 2'b10;
  localparam logic [1:0] OPC_RSVD  = 2'b11;

  // Whole-instruction value that cancels a running transfer when abort is built in
  localparam logic [7:0] ABORT_INSTR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'b00,
    ST_LOAD        = 2'b01,
    ST_STORE_PRIME = 2'b10,
    ST_STORE       = 2'b11
  } mau_state_e;

  // One-hot BRAM enable for a 2-bit BRAM select
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    sel_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mau_xfer_counter.sv
// rtl/mau_xfer_counter.sv - byte address counter with clear, enable and terminal-count flag
module mau_xfer_counter #(
  parameter int ADDR_W   = 6,
  parameter int TC_VALUE = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // Clear wins over enable so the FSM can stop the count on the terminal cycle
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == ADDR_W'(TC_VALUE));

endmodule

// File: rtl/mau_host_ctrl.sv
// rtl/mau_host_ctrl.sv - host-side LOAD/STORE sequencer for four matrix BRAMs (optional abort: MAU_HOST_CTRL_ABORT_EN)
module mau_host_ctrl
  import mau_pkg::*;
#(
  parameter int MATRIX_DIM = 8,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_instruction,
  input  logic [7:0]        data_in,
  input  logic [31:0]       bram_rdata,
  output logic [3:0]        bram_we,
  output logic [3:0]        bram_re,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  output logic [7:0]        data_out,
  output logic              data_out_valid,
  output logic              busy_flag
);

  localparam int N = MATRIX_DIM * MATRIX_DIM;

  mau_state_e        state_q, state_d;
  logic [7:0]        last_instr_q, last_instr_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        data_out_q, data_out_d;

  logic [ADDR_W-1:0] cnt;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;

  logic [1:0]        host_opc;
  logic [7:0]        rd_byte;

  assign host_opc   = host_instruction[OPC_MSB:OPC_LSB];
  assign rd_byte    = bram_rdata[{sel_q, 3'b000} +: 8];
  assign bram_wdata = data_in;
  assign busy_flag  = (state_q != ST_IDLE);

  // While STORE is streaming, the read byte goes straight out so it is valid in
  // the same cycle as data_out_valid; otherwise the last streamed byte is held.
  assign data_out = (state_q == ST_STORE) ? rd_byte : data_out_q;

  mau_xfer_counter #(
    .ADDR_W  (ADDR_W),
    .TC_VALUE(N - 1)
  ) u_xfer_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(cnt),
    .tc   (cnt_tc)
  );

  // Next-state, counter control and BRAM strobes
  always_comb begin
    state_d        = state_q;
    last_instr_d   = last_instr_q;
    sel_d          = sel_q;
    data_out_d     = data_out_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    bram_we        = 4'b0000;
    bram_re        = 4'b0000;
    bram_addr      = cnt;
    data_out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        // Only an edge on the instruction bus is a new command; every changed
        // value (NOP and reserved included) becomes the new reference.
        if (host_instruction != last_instr_q) begin
          last_instr_d = host_instruction;
          if (host_opc == OPC_LOAD) begin
            sel_d   = host_instruction[SEL_MSB:SEL_LSB];
            state_d = ST_LOAD;
          end else if (host_opc == OPC_STORE) begin
            sel_d   = host_instruction[SEL_MSB:SEL_LSB];
            state_d = ST_STORE_PRIME;
          end
        end
      end

      ST_LOAD: begin
        bram_we = sel_onehot(sel_q);
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_STORE_PRIME: begin
        // Issue the read of byte 0 so it arrives in the first STORE cycle
        bram_re   = sel_onehot(sel_q);
        bram_addr = '0;
        state_d   = ST_STORE;
      end

      ST_STORE: begin
        data_out_valid = 1'b1;
        data_out_d     = rd_byte;
        if (cnt_tc) begin
          // Last byte: nothing left to prefetch, and the address must not wrap
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bram_re   = sel_onehot(sel_q);
          bram_addr = cnt + ADDR_W'(1);
          cnt_en    = 1'b1;
        end
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

`ifdef MAU_HOST_CTRL_ABORT_EN
    // Abort drops straight back to IDLE; bytes already written stay in the BRAM
    if ((state_q != ST_IDLE) && (host_instruction == ABORT_INSTR)) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      cnt_en  = 1'b0;
    end
`endif
  end

  // State, instruction history, BRAM select and held output byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_instr_q <= 8'h00;
      sel_q        <= 2'b00;
      data_out_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_instr_q <= last_instr_d;
      sel_q        <= sel_d;
      data_out_q   <= data_out_d;
    end
  end

endmodule

// File: tb/tb_mau_host_ctrl.sv
// tb/tb_mau_host_ctrl.sv - directed self-checking bench for mau_host_ctrl
module tb_mau_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  host_instruction;
  logic [7:0]  data_in;
  logic [31:0] bram_rdata = 32'h0;
  logic [3:0]  bram_we;
  logic [3:0]  bram_re;
  logic [5:0]  bram_addr;
  logic [7:0]  bram_wdata;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        busy_flag;

  logic [7:0]  mem [4][64];

  int checks = 0;
  int errors = 0;

  mau_host_ctrl #(
    .MATRIX_DIM(8),
    .ADDR_W    (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_instruction(host_instruction),
    .data_in         (data_in),
    .bram_rdata      (bram_rdata),
    .bram_we         (bram_we),
    .bram_re         (bram_re),
    .bram_addr       (bram_addr),
    .bram_wdata      (bram_wdata),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .busy_flag       (busy_flag)
  );

  always #5 clk = ~clk;

  // Four byte-wide BRAMs with one-cycle registered read
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bram_we[i]) mem[i][bram_addr] <= bram_wdata;
      if (bram_re[i]) bram_rdata[8*i +: 8] <= mem[i][bram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_check(input int b, input logic [7:0] base, input int lo, input int hi,
                           output int bad);
    logic [7:0] exp;
    bad = 0;
    for (int k = lo; k <= hi; k++) begin
      exp = base + 8'(k);
      if (mem[b][k] !== exp) bad++;
    end
  endtask

  task automatic run_load(input logic [7:0] instr, input logic [7:0] base,
                          output int cycles, output int bad);
    logic [3:0] exp_we;
    exp_we = 4'b0001 << instr[7:6];
    host_instruction = instr;
    data_in = base;
    tick();
    cycles = 0;
    bad = 0;
    while (busy_flag && cycles < 200) begin
      data_in = base + 8'(cycles);
      #1;
      if (bram_we !== exp_we || bram_re !== 4'b0 || bram_addr !== 6'(cycles) ||
          bram_wdata !== data_in) bad++;
      tick();
      cycles++;
    end
  endtask

  task automatic run_store(input logic [7:0] instr, input logic [7:0] base,
                           output int cycles, output int nbytes, output int bad);
    host_instruction = instr;
    tick();
    cycles = 0;
    nbytes = 0;
    bad = 0;
    while (busy_flag && cycles < 200) begin
      if (data_out_valid) begin
        if (data_out !== base + 8'(nbytes)) bad++;
        nbytes++;
      end
      if (bram_we !== 4'b0) bad++;
      cycles++;
      tick();
    end
  endtask

  initial begin
    int cyc;
    int nb;
    int bad;
    bit fired;

    rst = 1'b1;
    host_instruction = 8'h00;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    check("rst_busy", busy_flag, 0);
    check("rst_we", bram_we, 0);
    check("rst_re", bram_re, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    rst = 1'b0;

    // NOP held after reset
    bad = 0;
    repeat (4) begin
      tick();
      if (busy_flag !== 1'b0 || bram_we !== 4'b0 || bram_re !== 4'b0) bad++;
    end
    check("nop_idle", bad, 0);

    // LOAD B0 with 0..63
    run_load(8'h04, 8'h00, cyc, bad);
    check("load_b0_cycles", cyc, 64);
    check("load_b0_strobes", bad, 0);
    mem_check(0, 8'h00, 0, 63, bad);
    check("b0_contents", bad, 0);

    // LOAD B1, B2, B3 in turn
    run_load(8'h44, 8'h40, cyc, bad);
    check("load_b1_cycles", cyc, 64);
    check("load_b1_strobes", bad, 0);
    run_load(8'h84, 8'hA0, cyc, bad);
    check("load_b2_cycles", cyc, 64);
    check("load_b2_strobes", bad, 0);
    run_load(8'hC4, 8'hC0, cyc, bad);
    check("load_b3_cycles", cyc, 64);
    check("load_b3_strobes", bad, 0);
    mem_check(0, 8'h00, 0, 63, bad);
    check("b0_untouched", bad, 0);
    mem_check(1, 8'h40, 0, 63, bad);
    check("b1_contents", bad, 0);
    mem_check(2, 8'hA0, 0, 63, bad);
    check("b2_contents", bad, 0);
    mem_check(3, 8'hC0, 0, 63, bad);
    check("b3_contents", bad, 0);

    // Unchanged instruction does not restart
    bad = 0;
    repeat (5) begin
      tick();
      if (busy_flag !== 1'b0 || bram_we !== 4'b0) bad++;
    end
    check("held_no_restart", bad, 0);

    // STORE B2
    run_store(8'h88, 8'hA0, cyc, nb, bad);
    check("store_b2_cycles", cyc, 65);
    check("store_b2_bytes", nb, 64);
    check("store_b2_data", bad, 0);
    check("store_hold_data_out", data_out, 8'hDF);
    check("store_done_valid", data_out_valid, 0);

    // Reset in the middle of a LOAD at byte 20
    host_instruction = 8'h04;
    tick();
    for (int k = 0; k < 20; k++) begin
      data_in = 8'h30 + 8'(k);
      tick();
    end
    data_in = 8'h44;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_flag, 0);
    check("midrst_we", bram_we, 0);
    check("midrst_addr", bram_addr, 0);
    tick();
    check("midrst_busy_next", busy_flag, 0);
    check("midrst_we_next", bram_we, 0);
    rst = 1'b0;
    mem_check(0, 8'h30, 0, 19, bad);
    check("midrst_kept_bytes", bad, 0);
    mem_check(0, 8'h00, 20, 63, bad);
    check("midrst_rest_untouched", bad, 0);
    run_load(8'h04, 8'h10, cyc, bad);
    check("reload_cycles", cyc, 64);
    check("reload_strobes", bad, 0);
    mem_check(0, 8'h10, 0, 63, bad);
    check("reload_contents", bad, 0);

    // 8'hFF during STORE B3 at byte 10
    host_instruction = 8'hC8;
    tick();
    cyc = 0;
    nb = 0;
    bad = 0;
    fired = 1'b0;
    while (busy_flag && cyc < 200) begin
      if (data_out_valid) begin
        if (data_out !== 8'hC0 + 8'(nb)) bad++;
        nb++;
        if (nb == 11 && !fired) begin
          host_instruction = 8'hFF;
          fired = 1'b1;
        end
      end
      cyc++;
      tick();
    end
    check("ff_store_data", bad, 0);
    check("ff_valid_after", data_out_valid, 0);
    check("ff_re_after", bram_re, 0);
`ifdef MAU_HOST_CTRL_ABORT_EN
    check("abort_bytes", nb, 11);
    check("abort_cycles", cyc, 12);
`else
    check("ff_ignored_bytes", nb, 64);
    check("ff_ignored_cycles", cyc, 65);
`endif

    // 8'hFF and reserved opcode in IDLE start nothing
    bad = 0;
    repeat (4) begin
      tick();
      if (busy_flag !== 1'b0) bad++;
    end
    host_instruction = 8'h0C;
    repeat (4) begin
      tick();
      if (busy_flag !== 1'b0 || bram_we !== 4'b0 || bram_re !== 4'b0) bad++;
    end
    check("reserved_ignored", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
